// File: rtl/whack_score_tracker.sv
// whack_score_tracker: whack detection, scoring, miss counting and IDLE/PLAY/DONE sequencing.
// Optional MISS_PENALTY_EN: each miss cycle also takes one point off the score, floored at 0.
module whack_score_tracker #(
  parameter int NUM_MOLES  = 16,
  parameter int MAX_SCORE  = 9999,
  parameter int MISS_WIDTH = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  game_active_i,
  input  logic                  tick_i,
  input  logic [NUM_MOLES-1:0]  moles_i,
  input  logic [NUM_MOLES-1:0]  switches_i,
  output logic                  whacked_o,
  output logic [NUM_MOLES-1:0]  hit_mask_o,
  output logic [15:0]           score_o,
  output logic [MISS_WIDTH-1:0] miss_count_o,
  output logic [15:0]           high_score_o,
  output logic [1:0]            state_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DONE = 2'b10} state_e;
  localparam int CW = $clog2(NUM_MOLES + 1);

  state_e                state_q, state_d;
  logic [NUM_MOLES-1:0]  sw_s1_q, sw_s2_q, sw_prev_q, mask_q, mask_d;
  logic [15:0]           score_q, score_d, high_q, high_d;
  logic [MISS_WIDTH-1:0] miss_q, miss_d;
  logic                  active_prev_q, whacked_q, whacked_d;
  logic [NUM_MOLES-1:0]  toggled, hits;
  logic                  start, miss;
  logic [CW-1:0]         cnt;
  logic [17:0]           sum;
  logic [15:0]           clamped;

  always_comb begin
    toggled = sw_s2_q ^ sw_prev_q;
    start   = game_active_i & ~active_prev_q;
    hits    = toggled & moles_i & ~mask_q;
    miss    = |(toggled & ~moles_i);
    cnt     = '0;
    for (int i = 0; i < NUM_MOLES; i++) cnt = cnt + CW'(hits[i]);
    sum = 18'(score_q) + 18'(cnt);
`ifdef MISS_PENALTY_EN
    sum = sum - 18'(miss);
`endif
    // bit 17 set means the penalty drove the sum below zero
    clamped   = sum[17] ? 16'd0 : (sum > 18'(MAX_SCORE) ? 16'(MAX_SCORE) : sum[15:0]);
    state_d   = state_q;
    score_d   = score_q;
    miss_d    = miss_q;
    mask_d    = mask_q;
    high_d    = high_q;
    whacked_d = 1'b0;
    if (state_q == PLAY) begin
      if (!game_active_i) begin
        state_d = DONE;
        high_d  = score_q > high_q ? score_q : high_q;
      end else begin
        score_d   = clamped;
        miss_d    = (miss && !(&miss_q)) ? miss_q + MISS_WIDTH'(1) : miss_q;
        mask_d    = tick_i ? '0 : (mask_q | hits);
        whacked_d = |hits;
      end
    end else if (start) begin
      state_d = PLAY;
      score_d = '0;
      miss_d  = '0;
      mask_d  = '0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= IDLE;
      sw_s1_q       <= '0;
      sw_s2_q       <= '0;
      sw_prev_q     <= '0;
      active_prev_q <= 1'b0;
      mask_q        <= '0;
      score_q       <= '0;
      high_q        <= '0;
      miss_q        <= '0;
      whacked_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sw_s1_q       <= switches_i;
      sw_s2_q       <= sw_s1_q;
      sw_prev_q     <= sw_s2_q;
      active_prev_q <= game_active_i;
      mask_q        <= mask_d;
      score_q       <= score_d;
      high_q        <= high_d;
      miss_q        <= miss_d;
      whacked_q     <= whacked_d;
    end
  end

  assign whacked_o    = whacked_q;
  assign hit_mask_o   = mask_q;
  assign score_o      = score_q;
  assign miss_count_o = miss_q;
  assign high_score_o = high_q;
  assign state_o      = state_q;
endmodule
